// File: rtl/glb_rd_port.sv
// Read-port adapter between a GLB SRAM bank with fixed read latency and a
// streaming consumer; credit-counted so that no returned word is ever dropped.
module glb_rd_port #(
    parameter int SRAM_WIDTH = 256,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LAT     = 1,
    parameter int OUT_DEPTH  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Clr,
    input  logic [ADDR_WIDTH-1:0] RdAddr,
    input  logic                  RdAddrVld,
    output logic                  RdAddrRdy,
    output logic [SRAM_WIDTH-1:0] RdDat,
    output logic                  RdDatVld,
    input  logic                  RdDatRdy,
    output logic                  SRAM_Ce,
    output logic [ADDR_WIDTH-1:0] SRAM_Addr,
    input  logic [SRAM_WIDTH-1:0] SRAM_RdDat,
    output logic [CNT_WIDTH-1:0]  Count
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(OUT_DEPTH);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(OUT_DEPTH - 1);

    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_occ;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [RD_LAT-1:0]     r_vpipe;
    logic [SRAM_WIDTH-1:0] r_mem [OUT_DEPTH];

    logic w_empty;
    logic w_addrRdy;
    logic w_ce;
    logic w_push;
    logic w_pop;

    // Pointers wrap explicitly so OUT_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty   = (r_occ == '0);
    assign w_addrRdy = !Clr && (r_count < DEPTH_C);
    assign w_ce      = RdAddrVld && w_addrRdy;
    assign w_push    = r_vpipe[RD_LAT-1] && !Clr;
    assign w_pop     = RdDatVld && RdDatRdy;

    assign RdAddrRdy = w_addrRdy;
    assign SRAM_Ce   = w_ce;
    assign SRAM_Addr = RdAddr;
    assign RdDatVld  = !w_empty && !Clr;
    assign RdDat     = w_empty ? '0 : r_mem[r_rptr];
    assign Count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe <= '0;
        end else if (Clr) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_ce;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // Credits cover words in flight as well as words parked in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (Clr) begin
            r_count <= '0;
        end else if (w_ce && !w_pop) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end else if (!w_ce && w_pop) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (Clr) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= nextPtr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= nextPtr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + CNT_WIDTH'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= SRAM_RdDat;
        end
    end

    a_noWriteWhenFull: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_occ == DEPTH_C)));
    a_noPopWhenEmpty: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && w_empty));
    a_creditBalance: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(r_count) == int'(r_occ) + $countones(r_vpipe)));

endmodule

// File: tb/tb_glb_rd_port.sv
// Randomised scoreboard bench for glb_rd_port: a behavioural SRAM, a
// transaction-level model of accepted reads and a decoupled output monitor.
module tb_glb_rd_port;

    localparam int SRAM_WIDTH = 256;
    localparam int ADDR_WIDTH = 16;
    localparam int RD_LAT     = 1;
    localparam int OUT_DEPTH  = 4;
    localparam int CNT_WIDTH  = 3;
    localparam int W          = SRAM_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  Clr = 1'b0;
    logic [ADDR_WIDTH-1:0] RdAddr = '0;
    logic                  RdAddrVld = 1'b0;
    logic                  RdAddrRdy;
    logic [SRAM_WIDTH-1:0] RdDat;
    logic                  RdDatVld;
    logic                  RdDatRdy = 1'b0;
    logic                  SRAM_Ce;
    logic [ADDR_WIDTH-1:0] SRAM_Addr;
    logic [SRAM_WIDTH-1:0] SRAM_RdDat;
    logic [CNT_WIDTH-1:0]  Count;

    glb_rd_port #(
        .SRAM_WIDTH(SRAM_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .RD_LAT    (RD_LAT),
        .OUT_DEPTH (OUT_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Clr       (Clr),
        .RdAddr    (RdAddr),
        .RdAddrVld (RdAddrVld),
        .RdAddrRdy (RdAddrRdy),
        .RdDat     (RdDat),
        .RdDatVld  (RdDatVld),
        .RdDatRdy  (RdDatRdy),
        .SRAM_Ce   (SRAM_Ce),
        .SRAM_Addr (SRAM_Addr),
        .SRAM_RdDat(SRAM_RdDat),
        .Count     (Count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Contents of the SRAM: every address holds a distinct, non-zero word.
    function automatic logic [SRAM_WIDTH-1:0] wordAt(input logic [ADDR_WIDTH-1:0] a);
        logic [SRAM_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < SRAM_WIDTH / 32; i++) begin
            w[i*32 +: 32] = (32'(a) + 32'h0000_1000 * 32'(i + 1)) ^ 32'hA5C3_0000;
        end
        return w;
    endfunction

    // Behavioural SRAM with RD_LAT cycles from CE to data.
    logic [SRAM_WIDTH-1:0] sramPipe [RD_LAT];
    always @(posedge clk) begin
        if (SRAM_Ce) sramPipe[0] <= wordAt(SRAM_Addr);
        for (int i = 1; i < RD_LAT; i++) sramPipe[i] <= sramPipe[i-1];
    end
    assign SRAM_RdDat = sramPipe[RD_LAT-1];

    typedef struct {
        logic [SRAM_WIDTH-1:0] data;
        int                    rdyCyc;
    } exp_t;

    exp_t expQ[$];
    int   mdlCount = 0;
    int   checks = 0;
    int   failures = 0;
    logic acc;
    logic seenRdy;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of stimulus, checks the address side against the
    // model and records any accepted read in the scoreboard.
    task automatic applyStimulus(input logic vld, input logic [ADDR_WIDTH-1:0] addr,
                                 input logic rdy, input logic clr,
                                 output logic accepted, output logic dutRdy);
        logic expRdy;
        @(posedge clk);
        #1;
        RdAddrVld = vld;
        RdAddr    = addr;
        RdDatRdy  = rdy;
        Clr       = clr;
        @(negedge clk);
        expRdy = !clr && (mdlCount < OUT_DEPTH);
        dutRdy = RdAddrRdy;
        checkOutput("Count", W'(Count), W'(mdlCount));
        checkOutput("RdAddrRdy", W'(RdAddrRdy), W'(expRdy));
        checkOutput("SRAM_Ce", W'(SRAM_Ce), W'(vld && expRdy));
        if (vld && expRdy) checkOutput("SRAM_Addr", W'(SRAM_Addr), W'(addr));
        accepted = vld && expRdy;
        if (accepted) begin
            expQ.push_back('{data: wordAt(addr), rdyCyc: cyc + RD_LAT + 1});
            mdlCount++;
        end
        if (clr) begin
            expQ.delete();
            mdlCount = 0;
        end
    endtask

    // Output monitor: a word is visible from RD_LAT+1 cycles after its
    // acceptance until popped; nothing is visible while Clr is high.
    always begin
        logic expVld;
        @(negedge clk);
        #1;
        expVld = !Clr && (expQ.size() > 0) && (expQ[0].rdyCyc <= cyc);
        checkOutput("RdDatVld", W'(RdDatVld), W'(expVld));
        if (expVld && RdDatRdy) begin
            checkOutput("RdDat", RdDat, expQ[0].data);
            void'(expQ.pop_front());
            mdlCount--;
        end else if (!Clr && !expVld) begin
            checkOutput("RdDatEmpty", RdDat, '0);
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 60) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, acc, seenRdy);
            n++;
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc, seenRdy);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: %0d words still expected after %0d cycles",
                     name, expQ.size(), n);
            expQ.delete();
        end
    endtask

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        int accCnt;
        #3;
        checkOutput("rstCount", W'(Count), '0);
        checkOutput("rstRdDatVld", W'(RdDatVld), '0);
        checkOutput("rstRdDat", RdDat, '0);
        checkOutput("rstSramCe", W'(SRAM_Ce), '0);
        checkOutput("rstRdAddrRdy", W'(RdAddrRdy), W'(1'b1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read of 0x0010.
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc, seenRdy);
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, acc, seenRdy);
        drain("single");

        // Back-to-back streaming of addresses 0..63.
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, ADDR_WIDTH'(i), 1'b1, 1'b0, acc, seenRdy);
            if (!seenRdy) stalls++;
        end
        checkOutput("streamStalls", W'(stalls), '0);
        drain("stream");

        // Backpressure: only OUT_DEPTH reads may be accepted.
        accCnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, ADDR_WIDTH'(16'h0200 + i), 1'b0, 1'b0, acc, seenRdy);
            if (seenRdy) accCnt++;
        end
        checkOutput("bpAccepted", W'(accCnt), W'(OUT_DEPTH));
        checkOutput("bpCount", W'(Count), W'(OUT_DEPTH));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, ADDR_WIDTH'(16'h0300 + i), 1'b1, 1'b0, acc, seenRdy);
        end
        drain("bp");

        // Clr with two words in the FIFO and one in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ADDR_WIDTH'(16'h0400 + i), 1'b0, 1'b0, acc, seenRdy);
        end
        applyStimulus(1'b1, 16'h0499, 1'b1, 1'b1, acc, seenRdy);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc, seenRdy);
        applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, acc, seenRdy);
        drain("clr");

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, ADDR_WIDTH'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
                          acc, seenRdy);
        end
        drain("random");

        // Asynchronous reset with three reads outstanding.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ADDR_WIDTH'(16'h0500 + i), 1'b0, 1'b0, acc, seenRdy);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, acc, seenRdy);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arstCount", W'(Count), '0);
        checkOutput("arstRdDatVld", W'(RdDatVld), '0);
        checkOutput("arstRdDat", RdDat, '0);
        checkOutput("arstSramCe", W'(SRAM_Ce), '0);
        checkOutput("arstRdAddrRdy", W'(RdAddrRdy), W'(1'b1));
        expQ.delete();
        mdlCount = 0;
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, acc, seenRdy);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, acc, seenRdy);
        drain("afterReset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
